// File: rtl/spi_bus_pkg.sv
// Shared state encoding and sizing helper for the SPI bus arbiter.
package spi_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_XFER,
        S_GAP
    } state_e;

    // Ceil(log2(v)), never less than 1 so single-entry counters still get a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr_i, with wrap.
module rr_pick
    import spi_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && req_i[j] && j == (32'(ptr_i) + k) % NUM_REQ) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Transaction-level round-robin arbiter sharing one spi_master byte engine,
// with per-requester chip selects, CS setup/gap pacing and an idle watchdog.
module spi_bus_arbiter
    import spi_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     byte_valid,
    input  logic [8*NUM_REQ-1:0]   byte_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     byte_done,
    output logic [7:0]             rx_data,
    output logic [NUM_REQ-1:0]     timeout_err,
    output logic [NUM_REQ-1:0]     spi_cs_n,
    output logic                   m_start,
    output logic [7:0]             m_data_in,
    input  logic                   m_done,
    input  logic [7:0]             m_data_out,
    input  logic                   m_busy
);

    localparam int unsigned PW = clog2(NUM_REQ);
    localparam int unsigned CW = clog2((CS_SETUP > CS_GAP ? CS_SETUP : CS_GAP) + 1);
    localparam int unsigned WW = clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WW-1:0]      wd_q, wd_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
    logic               m_start_q, m_start_d;
    logic [7:0]         m_data_q, m_data_d;
    logic [NUM_REQ-1:0] byte_done_q, byte_done_d;
    logic [7:0]         rx_q, rx_d;
    logic [NUM_REQ-1:0] tmo_q, tmo_d;

    logic [NUM_REQ-1:0] pick;
    logic [PW-1:0]      pick_idx;
    logic               rel;
    logic               owner_valid;
    logic               owner_req;
    logic [7:0]         owner_byte;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick)
    );

    assign owner_valid = byte_valid[owner_q];
    assign owner_req   = req[owner_q];
    assign owner_byte  = byte_data[{owner_q, 3'b000} +: 8];

    always_comb begin
        pick_idx = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (pick[j]) pick_idx = PW'(j);
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        grant_d     = grant_q;
        cs_n_d      = cs_n_q;
        m_start_d   = 1'b0;
        m_data_d    = m_data_q;
        byte_done_d = '0;
        rx_d        = rx_q;
        tmo_d       = '0;
        rel         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    cs_n_d  = ~pick;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    wd_d    = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (32'(cnt_q) + 32'd1 >= CS_SETUP) begin
                    cnt_d   = '0;
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                // A byte offered while the master is still busy is dropped, not queued.
                if (owner_valid && !m_busy) begin
                    m_data_d  = owner_byte;
                    m_start_d = 1'b1;
                    wd_d      = '0;
                    state_d   = S_XFER;
                end else if (!owner_req) begin
                    rel = 1'b1;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    rel            = 1'b1;
                    tmo_d[owner_q] = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_XFER: begin
                if (m_done) begin
                    rx_d                 = m_data_out;
                    byte_done_d[owner_q] = 1'b1;
                    state_d              = S_ACTIVE;
                end
            end
            S_GAP: begin
                if (32'(cnt_q) + 32'd1 >= CS_GAP) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rel) begin
            grant_d  = '0;
            cs_n_d   = '1;
            rr_ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            cnt_d    = '0;
            state_d  = S_GAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            grant_q     <= '0;
            cs_n_q      <= '1;
            m_start_q   <= 1'b0;
            m_data_q    <= '0;
            byte_done_q <= '0;
            rx_q        <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            grant_q     <= grant_d;
            cs_n_q      <= cs_n_d;
            m_start_q   <= m_start_d;
            m_data_q    <= m_data_d;
            byte_done_q <= byte_done_d;
            rx_q        <= rx_d;
            tmo_q       <= tmo_d;
        end
    end

    assign grant       = grant_q;
    assign spi_cs_n    = cs_n_q;
    assign m_start     = m_start_q;
    assign m_data_in   = m_data_q;
    assign byte_done   = byte_done_q;
    assign rx_data     = rx_q;
    assign timeout_err = tmo_q;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~spi_cs_n));
    assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == S_ACTIVE && owner_valid && m_busy));

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one spi_master byte engine between NUM_REQ requesters, e.g. the IMU driver plus a magnetometer/config engine.
- Grants whole transactions round-robin and owns a per-requester chip select.
- Paces each SPI byte for the owner and enforces CS setup and inter-transaction gap timing.
- A watchdog reclaims the bus from a stalled owner.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- CS_SETUP, 2, clk cycles from CS assert to first byte allowed (0 legal).
- CS_GAP, 4, clk cycles CS stays high between transactions (minimum 1).
- TIMEOUT, 1023, clk cycles an owner may sit in ACTIVE without issuing a byte before forced release.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transaction request; held high for the whole transaction.
- byte_valid  in  NUM_REQ  one-cycle pulse: owner presents a byte.
- byte_data  in  8*NUM_REQ  byte for requester i is at [8i+7:8i].
- grant  out  NUM_REQ  one-hot owner indication, registered.
- byte_done  out  NUM_REQ  one-cycle pulse to the owner when its byte completes.
- rx_data  out  8  last received byte; valid on and after byte_done.
- timeout_err  out  NUM_REQ  one-cycle pulse to the owner on forced release.
- spi_cs_n  out  NUM_REQ  active-low chip selects.
- m_start  out  1  start pulse to spi_master.
- m_data_in  out  8  byte to spi_master.
- m_done  in  1  spi_master byte-complete pulse.
- m_data_out  in  8  spi_master received byte.
- m_busy  in  1  spi_master busy.

Behaviour:
- Reset values: grant=0, byte_done=0, timeout_err=0, rx_data=0, spi_cs_n=all 1, m_start=0, m_data_in=0. State is IDLE and rr_ptr=0.
- IDLE:
  - On any req, pick the first set bit searching from rr_ptr upward with wrap.
  - Register grant one-hot and drive that spi_cs_n low in the same edge; go SETUP.
  - No req: stay in IDLE.
  - Latency from req rising to grant/CS low is 1 cycle.
- SETUP: count CS_SETUP cycles, then go ACTIVE. With CS_SETUP=0, go ACTIVE on the next cycle.
- ACTIVE:
  - Owner byte_valid: load m_data_in from the owner slice, pulse m_start for 1 cycle, clear the watchdog, go XFER.
  - Owner req low with no byte_valid: release.
  - Otherwise the watchdog increments. At TIMEOUT, pulse timeout_err[owner] and release.
- XFER:
  - Wait for m_done, then latch rx_data<=m_data_out, pulse byte_done[owner], return to ACTIVE.
  - A req drop during XFER never aborts the byte: the byte completes, then ACTIVE sees req low and releases.
  - The watchdog is frozen in XFER.
- Release:
  - Deassert owner CS and grant, set rr_ptr=owner+1 (mod NUM_REQ), go GAP.
  - Count CS_GAP cycles with all CS high, then go IDLE.
- Non-owner byte_valid is ignored silently; no byte_done is produced for it.
- Owner byte_valid in SETUP, XFER or GAP is ignored. Requesters wait for grant, and for byte_done, before presenting the next byte.
- Simultaneous req from all requesters: grant follows rr order, so each requester wins exactly once per NUM_REQ transactions.
- At most one spi_cs_n is low at any time. No CS is low while in GAP or IDLE.
- m_busy is ignored except in ACTIVE: byte_valid while m_busy=1 is held off, meaning no m_start is issued and the byte is dropped. This is flagged by an assertion only.
- Reset mid-transaction: all CS high and all outputs at reset values immediately (asynchronous). spi_master is reset by the same rst_n.

Decomposition:
- Shared package (spi_bus_pkg) holds:
  - state encoding localparams: S_IDLE, S_SETUP, S_ACTIVE, S_XFER, S_GAP;
  - the counter width function clog2.
- One sub-module, rr_pick: combinational round-robin priority picker over NUM_REQ with rr_ptr input and one-hot output.
- spi_master stays external; this block only talks to its start/data/done interface.

Test Plan:
- Single requester 0, 3-byte transaction 0xBB,0x00,0x00 with a master model returning 0x11,0x22:
  - grant[0] and cs_n[0]=0 one cycle after req;
  - first m_start no earlier than CS_SETUP cycles later;
  - three byte_done pulses, last rx_data=0x22;
  - CS high for ≥4 cycles after req drops.
- req=2'b11 asserted together and held for 3 transactions each:
  - grant order 0,1,0,1,0,1;
  - spi_cs_n never 2'b00;
  - GAP ≥4 cycles between each.
- Requester 1 pulses byte_valid while requester 0 owns the bus: no m_start, no byte_done[1], requester 0 traffic unaffected.
- Owner drops req in the middle of a byte: m_done still produces byte_done; CS rises on the release cycle after.
- Owner holds req with no bytes for TIMEOUT=1023 cycles: timeout_err[owner] pulses once, CS rises, the waiting requester is granted after GAP.
- Assert rst_n low during XFER: cs_n=all 1, grant=0 asynchronously. After release, a fresh req gets a grant normally.
